// File: rtl/spi_gain_cfg_pkg.sv
// Shared frame geometry and FSM encoding for the SPI gain configuration port.
package spi_gain_cfg_pkg;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StShift  = 2'b01,
    StCommit = 2'b10,
    StDone   = 2'b11
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with a registered previous sample for edge detection.
module sync_edge #(
  parameter int unsigned Stages = 2,
  parameter logic        RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic toggle
);

  logic [Stages-1:0] chain_q;
  logic              prev_q;
  logic [Stages:0]   fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {Stages{RstVal}};
      prev_q  <= RstVal;
      fill_q  <= '0;
    end else begin
      chain_q <= {chain_q[Stages-2:0], d};
      prev_q  <= chain_q[Stages-1];
      fill_q  <= {fill_q[Stages-1:0], 1'b1};
    end
  end

  assign level = chain_q[Stages-1];
  // Suppress the artificial transition from the reset value until real samples fill the chain.
  assign toggle = (level ^ prev_q) & fill_q[Stages];

endmodule

// File: rtl/spi_gain_cfg.sv
// SPI mode-0 slave that turns 16-bit address/data frames into gain bank write strobes.
module spi_gain_cfg
  import spi_gain_cfg_pkg::*;
#(
  parameter int unsigned ADDR_MAX    = 9,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic              err_clr,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              err_addr,
  output logic              err_short
);

  localparam int unsigned       Stages  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(ADDR_MAX);

  logic sclk_lvl, sclk_tgl, cs_lvl, cs_tgl, mosi_s;
  logic sclk_rise, cs_fall;
  logic [Stages-1:0] mosi_q;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]   shreg_q, shreg_d, frame_next;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      data_q;
  logic                   err_addr_q, err_short_q;
  logic                   set_addr, set_short, load, last_bit;

  sync_edge #(.Stages(Stages), .RstVal(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (sclk),
    .level  (sclk_lvl),
    .toggle (sclk_tgl)
  );

  sync_edge #(.Stages(Stages), .RstVal(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (cs_n),
    .level  (cs_lvl),
    .toggle (cs_tgl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[Stages-2:0], mosi};
  end

  assign mosi_s     = mosi_q[Stages-1];
  assign sclk_rise  = sclk_tgl & sclk_lvl;
  assign cs_fall    = cs_tgl & ~cs_lvl;
  assign frame_next = {shreg_q[FRAME_LEN-2:0], mosi_s};
  assign last_bit   = (cnt_q == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    set_addr  = 1'b0;
    set_short = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      StShift: begin
        if (cs_lvl) begin
          set_short = 1'b1;
          state_d   = StIdle;
        end else if (sclk_rise) begin
          shreg_d = frame_next;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_bit) begin
            if (frame_next[FRAME_LEN-1 -: ADDR_W] <= AddrMax) begin
              load    = 1'b1;
              state_d = StCommit;
            end else begin
              set_addr = 1'b1;
              state_d  = StDone;
            end
          end
        end
      end
      StCommit: state_d = StDone;
      StDone: begin
        if (cs_lvl) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    we   = (state_q == StCommit);
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      shreg_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      err_addr_q  <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      // Loaded on entry to the commit state so values are valid while we is high.
      if (load) begin
        addr_q <= frame_next[FRAME_LEN-1 -: ADDR_W];
        data_q <= frame_next[DATA_W-1:0];
      end
      err_addr_q  <= set_addr | (err_addr_q & ~err_clr);
      err_short_q <= set_short | (err_short_q & ~err_clr);
    end
  end

  assign addr      = addr_q;
  assign data_out  = data_q;
  assign err_addr  = err_addr_q;
  assign err_short = err_short_q;

endmodule

// File: doc/spi_gain_cfg.md
SPI_GAIN_CFG -- requirements
Module: spi_gain_cfg

Interface
REQ-001 Parameter ADDR_MAX, default 9: highest gain register address accepted; addresses 0..9 map to bands 1..10.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizers; minimum 2.
REQ-003 clk  input  1  system clock, single domain, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk, mode 0 (idle low, sample on rising edge).
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 mosi  input  1  SPI serial data, MSB first, asynchronous to clk.
REQ-008 err_clr  input  1  synchronous clear of the sticky error flags.
REQ-009 we  output  1  single-cycle write strobe to the gain register bank.
REQ-010 addr  output  8  gain register address, valid while we=1, held afterwards.
REQ-011 data_out  output  8  raw 8-bit gain code for the bank's Q5.8 converter, valid while we=1, held afterwards.
REQ-012 busy  output  1  high while a frame is in progress (cs_n low, synchronized).
REQ-013 err_addr  output  1  sticky: a complete frame carried addr > ADDR_MAX.
REQ-014 err_short  output  1  sticky: cs_n deasserted before 16 bits were received.

Function
REQ-015 sclk, cs_n and mosi shall each pass through SYNC_STAGES flip-flops; all decisions use the synchronized versions only.
REQ-016 A sclk rising edge shall be detected as synchronized sclk = 1 with its previous sample = 0; it produces exactly one sample event.
REQ-017 The FSM shall have states IDLE, SHIFT, DONE and COMMIT.
REQ-018 IDLE -> SHIFT on synchronized cs_n falling; bit counter cleared to 0 and shift register cleared.
REQ-019 In SHIFT, each sample event shifts mosi into a 16-bit register LSB-side and increments the bit counter.
REQ-020 Frame format: bits 15..8 = address, bits 7..0 = data, both MSB first.
REQ-021 On the 16th sample event the FSM shall go to COMMIT when address <= ADDR_MAX, otherwise set err_addr and go to DONE.
REQ-022 COMMIT shall last exactly one cycle: we=1, and addr/data_out load the frame values in the same cycle; the next state is DONE.
REQ-023 Latency: we shall rise in the clk cycle immediately after the cycle in which the 16th sample event is detected.
REQ-024 In DONE, further sample events shall be ignored, with no second write, until cs_n rises; then the FSM returns to IDLE.
REQ-025 In SHIFT, cs_n rising with bit count < 16 shall set err_short, produce no write and return to IDLE.
REQ-026 Any sclk edge while cs_n is high shall be ignored.
REQ-027 err_clr=1 clears both sticky flags; if a set condition occurs in the same cycle, set wins.
REQ-028 Outside COMMIT, we=0; addr and data_out change only in COMMIT.
REQ-029 busy=1 in SHIFT, COMMIT and DONE, and 0 in IDLE.
REQ-030 Operation is guaranteed for clk frequency >= 8x sclk frequency; there is no guaranteed behaviour below that.

Reset
REQ-031 rst_n low shall asynchronously force the FSM to IDLE; bit counter, shift register and synchronizers (cs_n chain to 1, others to 0) are reset.
REQ-032 Reset values: we=0, addr=0, data_out=0, busy=0, err_addr=0, err_short=0.
REQ-033 Reset asserted mid-frame aborts the frame with no write; after release, a new frame starts only on a fresh cs_n falling edge.

Structure
REQ-034 The frame length (16), address width (8), data width (8) and FSM state encoding shall live in the shared equalizer package.
REQ-035 The synchronizer chain plus edge detector shall be one reusable sub-module, sync_edge, instantiated for sclk and cs_n; mosi uses the synchronizer only.
REQ-036 The block contains no gain conversion; conversion remains in the register bank.

Verification
REQ-037 Frame 0x03,0x40 at sclk=clk/10 -> one we pulse with addr=0x03 and data_out=0x40, one cycle after the 16th edge; no error.
REQ-038 Frame 0x0A,0x55 -> no we pulse; err_addr=1; addr and data_out keep their previous values.
REQ-039 cs_n rises after 9 bits -> no we pulse; err_short=1; busy=0 two or three cycles later.
REQ-040 Frame 0x09,0xFF followed by 8 extra clocks under the same cs_n -> exactly one we pulse with addr=0x09 and data_out=0xFF.
REQ-041 rst_n pulsed low after 12 bits, then a full frame 0x00,0x20 -> the only write is addr=0x00, data_out=0x20.
REQ-042 err_clr raised in the same cycle as a new address error -> err_addr stays 1; err_clr alone on a later cycle -> err_addr=0.
